clk_divider_prog: RTL and testbench

Runtime-programmable integer clock divider, successor to the fixed divide-by-5 block. Produces two outputs from sys_clk: a divided clock clk_out with 50% duty for even and odd ratios, and a one-cycle enable pulse clk_flag for logic that stays on sys_clk. The ratio is loaded from a config register and changes glitch-free at period boundaries. Gated by an enable.

---
 rtl/clk_div_pkg.sv | 20 ++
 rtl/div_cfg_shadow.sv | 75 +++++++
 rtl/clk_divider_prog.sv | 109 ++++++++++
 tb/tb_clk_divider_prog.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider.
//   CntWDefault : default divisor/counter width
//   DivMin      : smallest legal divide ratio; smaller requests are clamped to it
//   state_e     : run-control states
//   half_up()   : ceil(n/2), the counter value at which the high phase begins
package clk_div_pkg;

  localparam int unsigned CntWDefault = 8;
  localparam int unsigned DivMin      = 2;

  typedef enum logic {
    StIdle,
    StRun
  } state_e;

  function automatic int unsigned half_up(input int unsigned n);
    return n - (n / 2);
  endfunction

endpackage

// File: rtl/div_cfg_shadow.sv
// Shadow register for the divide ratio. A load is parked in a pending slot until the
// top signals a safe boundary (period end or idle), so the active ratio never changes
// mid-period.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   div_val_i     : requested ratio
//   div_load_i    : one-cycle strobe capturing div_val_i
//   apply_i       : high on edges where the pending ratio may take effect
//   div_act_o     : ratio currently in effect
//   cfg_err_o     : one-cycle pulse after a load that had to be clamped
module div_cfg_shadow
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W   = CntWDefault,
  parameter int unsigned DIV_RST = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [CNT_W-1:0] div_val_i,
  input  logic             div_load_i,
  input  logic             apply_i,
  output logic [CNT_W-1:0] div_act_o,
  output logic             cfg_err_o
);

  localparam logic [CNT_W-1:0] DivMinW = CNT_W'(DivMin);
  localparam logic [CNT_W-1:0] DivRstW = CNT_W'(DIV_RST);

  logic [CNT_W-1:0] div_act_q, div_act_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             pending_q, pending_d;
  logic             cfg_err_q, cfg_err_d;
  logic             too_small;
  logic [CNT_W-1:0] clamped;

  assign too_small = (div_val_i < DivMinW);
  assign clamped   = too_small ? DivMinW : div_val_i;

  always_comb begin
    div_act_d  = div_act_q;
    pend_div_d = pend_div_q;
    pending_d  = pending_q;
    cfg_err_d  = div_load_i & too_small;
    if (apply_i) begin
      // A load on the apply edge bypasses the pending slot.
      if (div_load_i) begin
        div_act_d = clamped;
        pending_d = 1'b0;
      end else if (pending_q) begin
        div_act_d = pend_div_q;
        pending_d = 1'b0;
      end
    end else if (div_load_i) begin
      pend_div_d = clamped;
      pending_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_act_q  <= DivRstW;
      pend_div_q <= DivRstW;
      pending_q  <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      div_act_q  <= div_act_d;
      pend_div_q <= pend_div_d;
      pending_q  <= pending_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign div_act_o = div_act_q;
  assign cfg_err_o = cfg_err_q;

endmodule

// File: rtl/clk_divider_prog.sv
// Runtime-programmable integer clock divider with 50% duty for even and odd ratios.
//   sys_clk, sys_rst_n : system clock, asynchronous active-low reset
//   en                 : run enable (level); stopping only happens at a period end
//   div_val, div_load  : requested ratio and its one-cycle load strobe
//   clk_out            : divided clock, period div_act sys_clk cycles
//   clk_flag           : one-cycle pulse in the last cycle of each divided period
//   div_act            : ratio currently in effect
//   cfg_err            : one-cycle pulse after a clamped (ratio < 2) load
module clk_divider_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W   = CntWDefault,
  parameter int unsigned DIV_RST = 5
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             clk_out,
  output logic             clk_flag,
  output logic [CNT_W-1:0] div_act,
  output logic             cfg_err
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_p_q, clk_p_d;
  logic             clk_n_q;
  logic             clk_flag_q, clk_flag_d;
  logic             period_end;
  logic             apply;
  logic             run_d;
  logic [CNT_W-1:0] high_start;

  assign period_end = (state_q == StRun) && (cnt_q == div_act - CNT_W'(1));
  assign apply      = (state_q == StIdle) || period_end;
  assign high_start = CNT_W'(half_up(32'(div_act)));

  div_cfg_shadow #(
    .CNT_W  (CNT_W),
    .DIV_RST(DIV_RST)
  ) u_cfg (
    .clk_i     (sys_clk),
    .rst_ni    (sys_rst_n),
    .div_val_i (div_val),
    .div_load_i(div_load),
    .apply_i   (apply),
    .div_act_o (div_act),
    .cfg_err_o (cfg_err)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (en) state_d = StRun;
      end
      StRun: begin
        if (period_end) begin
          cnt_d = '0;
          if (!en) state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
    // Outputs are registered from the next count. The ratio only changes when cnt_d
    // is 0, where both decodes are false for any ratio >= 2, so the current div_act
    // is the right one to compare against.
    run_d      = (state_d == StRun);
    clk_p_d    = run_d && (cnt_d >= high_start);
    clk_flag_d = run_d && (cnt_d == div_act - CNT_W'(1));
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      clk_p_q    <= 1'b0;
      clk_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clk_p_q    <= clk_p_d;
      clk_flag_q <= clk_flag_d;
    end
  end

  // Half-cycle delayed copy of the high phase, only for odd ratios, stretching the
  // trailing edge so the high time becomes N/2 cycles.
  always_ff @(negedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      clk_n_q <= 1'b0;
    end else begin
      clk_n_q <= clk_p_q & div_act[0];
    end
  end

  assign clk_out  = clk_p_q | clk_n_q;
  assign clk_flag = clk_flag_q;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Self-checking bench for clk_divider_prog: a period-position reference model checked
// every half cycle, a table of idle-time loads, directed corner sequences and a
// randomized run.
module tb_clk_divider_prog;

  localparam int unsigned DivRst = 5;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       en        = 1'b0;
  logic [7:0] div_val   = 8'd0;
  logic       div_load  = 1'b0;
  logic       clk_out;
  logic       clk_flag;
  logic [7:0] div_act;
  logic       cfg_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 sys_clk = ~sys_clk;

  clk_divider_prog #(
    .CNT_W  (8),
    .DIV_RST(DivRst)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .en       (en),
    .div_val  (div_val),
    .div_load (div_load),
    .clk_out  (clk_out),
    .clk_flag (clk_flag),
    .div_act  (div_act),
    .cfg_err  (cfg_err)
  );

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position k within the current period, ratio n, pending request.
  bit m_run      = 1'b0;
  int m_k        = 0;
  int m_n        = DivRst;
  bit m_pend     = 1'b0;
  int m_pend_n   = 0;
  bit e_p        = 1'b0;  // high-phase part of clk_out for this cycle
  bit e_flag     = 1'b0;
  bit e_err      = 1'b0;
  bit e_n_first  = 1'b0;  // odd-ratio extension during first half of this cycle
  bit e_n_second = 1'b0;  // odd-ratio extension during second half of this cycle

  initial forever begin
    @(posedge sys_clk or negedge sys_rst_n);
    if (!sys_rst_n) begin
      m_run = 0; m_k = 0; m_n = DivRst; m_pend = 0;
      e_p = 0; e_flag = 0; e_err = 0; e_n_first = 0; e_n_second = 0;
    end else begin
      bit was_end;
      int req;
      was_end = m_run && (m_k == m_n - 1);
      req     = (div_val < 8'd2) ? 2 : int'(div_val);
      e_err   = div_load && (div_val < 8'd2);
      if (!m_run || was_end) begin
        if (div_load) begin
          m_n = req; m_pend = 0;
        end else if (m_pend) begin
          m_n = m_pend_n; m_pend = 0;
        end
      end else if (div_load) begin
        m_pend_n = req; m_pend = 1;
      end
      if (!m_run) begin
        m_run = en; m_k = 0;
      end else if (was_end) begin
        m_run = en; m_k = 0;
      end else begin
        m_k++;
      end
      e_n_first  = e_n_second;
      e_p        = m_run && (m_k >= m_n - m_n / 2);
      e_flag     = m_run && (m_k == m_n - 1);
      e_n_second = e_p && (m_n % 2 == 1);
    end
  end

  initial begin
    #20;
    forever begin
      @(posedge sys_clk); #2;
      check("mdl_clk_out_h1", clk_out, e_p | e_n_first);
      check("mdl_clk_flag", clk_flag, e_flag);
      check("mdl_div_act", div_act, m_n);
      check("mdl_cfg_err", cfg_err, e_err);
      @(negedge sys_clk); #2;
      check("mdl_clk_out_h2", clk_out, e_p | e_n_second);
    end
  end

  task automatic tick();
    @(posedge sys_clk); #1;
  endtask

  task automatic load(input int v);
    div_val  = 8'(v);
    div_load = 1'b1;
    tick();
    div_load = 1'b0;
  endtask

  task automatic wait_k(input int k, input string name);
    int b = 0;
    while (!(m_run && m_k == k) && b < 600) begin
      tick();
      b++;
    end
    check(name, (b < 600), 1);
  endtask

  task automatic count_window(input int cycles, output int halves, output int flags);
    halves = 0;
    flags  = 0;
    repeat (cycles) begin
      @(posedge sys_clk); #3;
      halves += int'(clk_out);
      flags  += int'(clk_flag);
      @(negedge sys_clk); #3;
      halves += int'(clk_out);
    end
  endtask

  typedef struct {
    logic [7:0] div_val;
    logic [7:0] exp_act;
    logic       exp_err;
  } vec_t;

  vec_t vec[7];
  int   h, f, c;

  initial begin
    vec[0] = '{8'd0,   8'd2,   1'b1};
    vec[1] = '{8'd1,   8'd2,   1'b1};
    vec[2] = '{8'd2,   8'd2,   1'b0};
    vec[3] = '{8'd3,   8'd3,   1'b0};
    vec[4] = '{8'd255, 8'd255, 1'b0};
    vec[5] = '{8'd128, 8'd128, 1'b0};
    vec[6] = '{8'd5,   8'd5,   1'b0};

    // Reset state
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_clk_out", clk_out, 0);
    check("rst_clk_flag", clk_flag, 0);
    check("rst_div_act", div_act, DivRst);
    check("rst_cfg_err", cfg_err, 0);
    @(posedge sys_clk); #4;
    sys_rst_n = 1'b1;
    tick();

    // Loads while idle apply on the next edge; clamped loads pulse cfg_err
    for (int i = 0; i < 7; i++) begin
      load(int'(vec[i].div_val));
      check("tbl_div_act", div_act, vec[i].exp_act);
      check("tbl_cfg_err", cfg_err, vec[i].exp_err);
      check("tbl_idle_clk_out", clk_out, 0);
      tick();
      check("tbl_cfg_err_clear", cfg_err, 0);
    end

    // N=5: high for 5 half cycles per period, one flag per period
    en = 1'b1;
    repeat (12) tick();
    count_window(10, h, f);
    check("n5_high_halves", h, 10);
    check("n5_flags", f, 2);
    check("n5_div_act", div_act, 5);
    tick();

    // Ratio change 5 -> 4 loaded at cnt=1 waits for the period end
    wait_k(1, "n4_wait_k1");
    load(4);
    check("n4_hold_k2", div_act, 5);
    tick();
    check("n4_hold_k3", div_act, 5);
    tick();
    check("n4_hold_k4", div_act, 5);
    tick();
    check("n4_applied", div_act, 4);
    repeat (8) tick();
    count_window(8, h, f);
    check("n4_high_halves", h, 8);
    check("n4_flags", f, 2);
    tick();

    // Load 1 is clamped to 2
    load(1);
    check("n2_cfg_err_pulse", cfg_err, 1);
    tick();
    check("n2_cfg_err_clear", cfg_err, 0);
    repeat (8) tick();
    check("n2_div_act", div_act, 2);
    count_window(4, h, f);
    check("n2_high_halves", h, 4);
    check("n2_flags", f, 2);
    tick();

    // N=255: full-width ratio, high 127.5 cycles
    load(255);
    repeat (260) tick();
    check("n255_div_act", div_act, 255);
    count_window(255, h, f);
    check("n255_high_halves", h, 255);
    check("n255_flags", f, 1);
    tick();

    // N=7, en dropped at cnt=2: period completes, then idle
    load(7);
    repeat (300) tick();
    check("n7_div_act", div_act, 7);
    wait_k(2, "n7_wait_k2");
    en = 1'b0;
    f  = 0;
    repeat (4) begin
      tick();
      f += int'(clk_flag);
    end
    check("drop_flags_before_idle", f, 1);
    tick();
    repeat (5) begin
      @(negedge sys_clk); #2;
      check("idle_clk_out", clk_out, 0);
      check("idle_clk_flag", clk_flag, 0);
    end
    tick();
    en = 1'b1;
    c  = 0;
    do begin
      tick();
      c++;
    end while (!clk_flag && c < 50);
    check("reen_first_flag_cycles", c, 7);

    // Async reset in the high phase with a pending load
    wait_k(4, "rst_wait_k4");
    load(9);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("arst_clk_out", clk_out, 0);
    check("arst_clk_flag", clk_flag, 0);
    check("arst_div_act", div_act, DivRst);
    check("arst_cfg_err", cfg_err, 0);
    @(posedge sys_clk); #4;
    sys_rst_n = 1'b1;
    repeat (20) tick();
    check("arst_pending_lost", div_act, DivRst);

    // Randomized run against the model
    repeat (4000) begin
      en       = ($urandom_range(0, 15) != 0);
      div_load = ($urandom_range(0, 11) == 0);
      div_val  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                             : 8'($urandom_range(0, 12));
      tick();
    end
    div_load = 1'b0;
    en       = 1'b0;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
